md5_block_engine: RTL and testbench
===================================

MD5_BLOCK_ENGINE -- requirements
Module: md5_block_engine

Interface
REQ-001 SHALL provide parameter ROUNDS_PER_CYCLE, default 1: MD5 rounds retired per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 SHALL provide ports, in order: clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 start  in  1  request to hash one 512-bit block.
REQ-005 ready  out  1  engine idle, start will be accepted.
REQ-006 message  in  512  block; word i = message[32*i+31:32*i], little-endian MD5 words.
REQ-007 a_in, b_in, c_in, d_in  in  32 each  chaining state (IV or previous digest).
REQ-008 busy  out  1  block in progress.
REQ-009 done  out  1  one-cycle pulse, result valid.
REQ-010 a_out, b_out, c_out, d_out  out  32 each  result state.

Function
REQ-011 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start&ready; RUN->IDLE after the final round update.
REQ-012 On acceptance SHALL register message and a_in..d_in; later input changes SHALL not affect the block in progress.
REQ-013 SHALL keep a 6-bit round counter i, cleared on acceptance, advanced by ROUNDS_PER_CYCLE per RUN cycle; wrap from 64 to 0 ends RUN.
REQ-014 Round i SHALL use F=(b&c)|(~b&d), g=i for i 0-15; G=(d&b)|(~d&c), g=(5i+1) mod 16 for 16-31; H=b^c^d, g=(3i+5) mod 16 for 32-47; I=c^(b|~d), g=7i mod 16 for 48-63.
REQ-015 Each round: new_b = b + rotl(a + f + K[i] + M[g], s[i]); (a,b,c,d) <= (d,new_b,b,c); K and s per RFC 1321 internal constant tables; all adds modulo 2^32.
REQ-016 With ROUNDS_PER_CYCLE>1, rounds SHALL be chained combinationally within one cycle; no group crosses a 16-round function boundary.
REQ-017 done SHALL assert exactly 64/ROUNDS_PER_CYCLE rising edges after the edge that accepted start, for one cycle.
REQ-018 a_out..d_out SHALL update only on the edge asserting done and SHALL hold until the next done.
REQ-019 ready = IDLE; busy = RUN; start while busy SHALL be ignored, with no queuing.
REQ-020 start in the same cycle done is high SHALL be accepted, giving back-to-back blocks with no idle gap.

Reset
REQ-021 rst_n low SHALL immediately force IDLE: ready=1, busy=0, done=0, a_out..d_out=0, counter=0, working registers=0.
REQ-022 Reset during RUN SHALL abort the block with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-023 Macro MD5_CHAIN_ADD_EN defined: result SHALL be the registered inputs plus the final working state, word-wise modulo 2^32, i.e. the standard digest update.
REQ-024 Macro undefined: result SHALL be the raw working state after round 63 with no feed-forward add, for per-round software chaining.

Verification
REQ-025 Chain add on, RPC=1; IV 67452301/efcdab89/98badcfe/10325476, block word0=00000080, others 0 (empty string) -> done 64 cycles after start; a..d_out = d98c1dd4/04b2008f/980980e9/7e42f8ec.
REQ-026 Same IV, "abc" block word0=80636261, word14=00000018, others 0, for RPC=1,2,4 -> 98500190/b04fd23c/7d3f96d6/727fe128; done latency 64/32/16 cycles.
REQ-027 start held high continuously with changing message -> blocks accepted only when ready; each done carries the result of the message sampled at its own acceptance.
REQ-028 rst_n pulsed low at round 30 -> ready=1, busy=0, outputs 0, no done; next "abc" start gives the REQ-026 result.
REQ-029 Chain add off, empty-string block -> outputs equal REQ-025 values minus the IV word-wise modulo 2^32.
REQ-030 start asserted during RUN -> ignored; done count equals accepted starts only.

Source files
------------

// File: rtl/md5_block_engine.sv
// md5_block_engine: iterative MD5 compression of one 512-bit block.
//
// Retires ROUNDS_PER_CYCLE rounds per clock (1, 2 or 4). Since each value
// divides 16, a group of rounds never spans two round functions.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start  / ready      start is accepted on a rising edge where ready is high
//   message             512-bit block, word i = message[32*i +: 32]
//   a_in..d_in          chaining state, sampled when start is accepted
//   busy                a block is in progress
//   done                one-cycle pulse: a_out..d_out now hold the new result
//   a_out..d_out        result; holds its value until the next done
//
// Handshake: when ready=1 and start=1 at a rising edge, message and a_in..d_in
// are captured. Later changes to these inputs do not affect that block. While
// busy=1, start is ignored and is not queued. ready is high during the cycle
// in which done is high, so a new block can follow with no idle cycle.
//
// Build option MD5_CHAIN_ADD_EN: when defined, the result is the captured
// input state plus the final working state (the standard digest update). When
// undefined, the result is the raw working state after round 63.
module md5_block_engine #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         ready,
    input  logic [511:0] message,
    input  logic [31:0]  a_in,
    input  logic [31:0]  b_in,
    input  logic [31:0]  c_in,
    input  logic [31:0]  d_in,
    output logic         busy,
    output logic         done,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
        $error("md5_block_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // RFC 1321 sine-derived additive constants.
    function automatic logic [31:0] k_const(input logic [5:0] i);
        logic [31:0] k;
        k = '0;
        case (i)
            6'd0:  k = 32'hd76aa478; 6'd1:  k = 32'he8c7b756; 6'd2:  k = 32'h242070db; 6'd3:  k = 32'hc1bdceee;
            6'd4:  k = 32'hf57c0faf; 6'd5:  k = 32'h4787c62a; 6'd6:  k = 32'ha8304613; 6'd7:  k = 32'hfd469501;
            6'd8:  k = 32'h698098d8; 6'd9:  k = 32'h8b44f7af; 6'd10: k = 32'hffff5bb1; 6'd11: k = 32'h895cd7be;
            6'd12: k = 32'h6b901122; 6'd13: k = 32'hfd987193; 6'd14: k = 32'ha679438e; 6'd15: k = 32'h49b40821;
            6'd16: k = 32'hf61e2562; 6'd17: k = 32'hc040b340; 6'd18: k = 32'h265e5a51; 6'd19: k = 32'he9b6c7aa;
            6'd20: k = 32'hd62f105d; 6'd21: k = 32'h02441453; 6'd22: k = 32'hd8a1e681; 6'd23: k = 32'he7d3fbc8;
            6'd24: k = 32'h21e1cde6; 6'd25: k = 32'hc33707d6; 6'd26: k = 32'hf4d50d87; 6'd27: k = 32'h455a14ed;
            6'd28: k = 32'ha9e3e905; 6'd29: k = 32'hfcefa3f8; 6'd30: k = 32'h676f02d9; 6'd31: k = 32'h8d2a4c8a;
            6'd32: k = 32'hfffa3942; 6'd33: k = 32'h8771f681; 6'd34: k = 32'h6d9d6122; 6'd35: k = 32'hfde5380c;
            6'd36: k = 32'ha4beea44; 6'd37: k = 32'h4bdecfa9; 6'd38: k = 32'hf6bb4b60; 6'd39: k = 32'hbebfbc70;
            6'd40: k = 32'h289b7ec6; 6'd41: k = 32'heaa127fa; 6'd42: k = 32'hd4ef3085; 6'd43: k = 32'h04881d05;
            6'd44: k = 32'hd9d4d039; 6'd45: k = 32'he6db99e5; 6'd46: k = 32'h1fa27cf8; 6'd47: k = 32'hc4ac5665;
            6'd48: k = 32'hf4292244; 6'd49: k = 32'h432aff97; 6'd50: k = 32'hab9423a7; 6'd51: k = 32'hfc93a039;
            6'd52: k = 32'h655b59c3; 6'd53: k = 32'h8f0ccc92; 6'd54: k = 32'hffeff47d; 6'd55: k = 32'h85845dd1;
            6'd56: k = 32'h6fa87e4f; 6'd57: k = 32'hfe2ce6e0; 6'd58: k = 32'ha3014314; 6'd59: k = 32'h4e0811a1;
            6'd60: k = 32'hf7537e82; 6'd61: k = 32'hbd3af235; 6'd62: k = 32'h2ad7d2bb; 6'd63: k = 32'heb86d391;
            default: k = '0;
        endcase
        return k;
    endfunction

    // Rotate amounts: four per round function, repeating every four rounds.
    function automatic logic [4:0] s_const(input logic [5:0] i);
        logic [4:0] s;
        s = '0;
        case ({i[5:4], i[1:0]})
            4'h0: s = 5'd7;  4'h1: s = 5'd12; 4'h2: s = 5'd17; 4'h3: s = 5'd22;
            4'h4: s = 5'd5;  4'h5: s = 5'd9;  4'h6: s = 5'd14; 4'h7: s = 5'd20;
            4'h8: s = 5'd4;  4'h9: s = 5'd11; 4'ha: s = 5'd16; 4'hb: s = 5'd23;
            4'hc: s = 5'd6;  4'hd: s = 5'd10; 4'he: s = 5'd15; 4'hf: s = 5'd21;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    // One MD5 round on packed state {a,b,c,d}.
    function automatic logic [127:0] md5_step(input logic [5:0] i, input logic [127:0] st,
                                              input logic [511:0] m);
        logic [31:0] a, b, c, d, f, sum;
        logic [3:0]  g;
        {a, b, c, d} = st;
        f = '0;
        g = '0;
        // The message index only depends on i mod 16, so 4-bit arithmetic
        // gives the mod-16 result directly.
        case (i[5:4])
            2'd0: begin f = (b & c) | (~b & d); g = i[3:0];                end
            2'd1: begin f = (d & b) | (~d & c); g = i[3:0] * 4'd5 + 4'd1;  end
            2'd2: begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5;  end
            2'd3: begin f = c ^ (b | ~d);       g = i[3:0] * 4'd7;         end
            default: ;
        endcase
        sum = a + f + k_const(i) + m[32*int'(g) +: 32];
        return {d, b + rotl(sum, s_const(i)), b, c};
    endfunction

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [127:0]   st_q, st_d;      // working {a,b,c,d}
    logic [511:0]   msg_q, msg_d;
    logic [127:0]   res_q, res_d;
    logic           done_q, done_d;
`ifdef MD5_CHAIN_ADD_EN
    logic [127:0]   iv_q, iv_d;      // captured chaining input, for feed-forward
`endif

    logic [127:0]   round_st;
    logic           last_group;

    // Chain this cycle's rounds combinationally.
    always_comb begin
        round_st = st_q;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            round_st = md5_step(cnt_q + 6'(r), round_st, msg_q);
        end
    end

    assign last_group = (cnt_q == 6'(64 - ROUNDS_PER_CYCLE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        msg_d   = msg_q;
        res_d   = res_q;
        done_d  = 1'b0;
`ifdef MD5_CHAIN_ADD_EN
        iv_d    = iv_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    st_d    = {a_in, b_in, c_in, d_in};
                    msg_d   = message;
`ifdef MD5_CHAIN_ADD_EN
                    iv_d    = {a_in, b_in, c_in, d_in};
`endif
                end
            end
            RUN: begin
                st_d  = round_st;
                cnt_d = cnt_q + 6'(ROUNDS_PER_CYCLE);  // wraps 64 -> 0
                if (last_group) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef MD5_CHAIN_ADD_EN
                    res_d = {iv_q[127:96] + round_st[127:96], iv_q[95:64] + round_st[95:64],
                             iv_q[63:32]  + round_st[63:32],  iv_q[31:0]  + round_st[31:0]};
`else
                    res_d = round_st;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            msg_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
`ifdef MD5_CHAIN_ADD_EN
            iv_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            msg_q   <= msg_d;
            res_q   <= res_d;
            done_q  <= done_d;
`ifdef MD5_CHAIN_ADD_EN
            iv_q    <= iv_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign {a_out, b_out, c_out, d_out} = res_q;

endmodule

// File: tb/tb_md5_block_engine.sv
// Testbench for md5_block_engine: three instances (1, 2 and 4 rounds per
// cycle) checked against known digests and a behavioural MD5 model.
module tb_md5_block_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   start_v, ready_v, busy_v, done_v;
  logic [511:0] message;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [31:0]  ao[3], bo[3], co[3], dd[3];

  int compared = 0;
  int mismatched = 0;
  logic [127:0] exp_q[$];
  int rpc_of[3] = '{1, 2, 4};

  md5_block_engine #(.ROUNDS_PER_CYCLE(1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .ready(ready_v[0]), .message(message),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .busy(busy_v[0]), .done(done_v[0]),
    .a_out(ao[0]), .b_out(bo[0]), .c_out(co[0]), .d_out(dd[0]));
  md5_block_engine #(.ROUNDS_PER_CYCLE(2)) dut_2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .ready(ready_v[1]), .message(message),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .busy(busy_v[1]), .done(done_v[1]),
    .a_out(ao[1]), .b_out(bo[1]), .c_out(co[1]), .d_out(dd[1]));
  md5_block_engine #(.ROUNDS_PER_CYCLE(4)) dut_4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .ready(ready_v[2]), .message(message),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .busy(busy_v[2]), .done(done_v[2]),
    .a_out(ao[2]), .b_out(bo[2]), .c_out(co[2]), .d_out(dd[2]));

  // ---------------- reference model ----------------
  logic [31:0] k_tab[64];
  int          s_tab[4][4];

  initial begin
    real v;
    for (int i = 0; i < 64; i++) begin
      v = $sin(real'(i + 1));
      if (v < 0.0) v = -v;
      k_tab[i] = 32'(longint'($floor(v * 4294967296.0)));
    end
    s_tab = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
  end

  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  // Full 64-round compression, then feed-forward only if the build enables it.
  function automatic logic [127:0] md5_ref(input logic [511:0] m, input logic [127:0] iv);
    logic [31:0] a, b, c, d, f, t, nb;
    int g;
    {a, b, c, d} = iv;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;                end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      t  = a + f + k_tab[i] + m[32*g +: 32];
      nb = b + rol(t, s_tab[i / 16][i % 4]);
      a = d; d = c; c = b; b = nb;
    end
`ifdef MD5_CHAIN_ADD_EN
    return {iv[127:96] + a, iv[95:64] + b, iv[63:32] + c, iv[31:0] + d};
`else
    return {a, b, c, d};
`endif
  endfunction

  // Known digests are for the chained form; unchained builds expect digest - IV.
  function automatic logic [127:0] from_digest(input logic [127:0] dig, input logic [127:0] iv);
`ifdef MD5_CHAIN_ADD_EN
    return dig;
`else
    return {dig[127:96] - iv[127:96], dig[95:64] - iv[95:64], dig[63:32] - iv[63:32], dig[31:0] - iv[31:0]};
`endif
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [127:0] res(input int k);
    return {ao[k], bo[k], co[k], dd[k]};
  endfunction

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one block to instance k, scrambles the inputs right after
  // acceptance, and waits (bounded) for done.
  task automatic run_block(input int k, input logic [511:0] m, input logic [127:0] iv,
                           output logic [127:0] r, output int lat);
    bit seen;
    @(negedge clk);
    message = m;
    {a_in, b_in, c_in, d_in} = iv;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    message = rand_block();
    {a_in, b_in, c_in, d_in} = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    seen = 0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_v[k]) seen = 1;
    end
    r = res(k);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    int           k;
    logic [511:0] msg;
    logic [127:0] iv;
    logic [127:0] dig;
  } vec_t;

  localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
  localparam logic [127:0] DIG_EMPTY = {32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec};
  localparam logic [127:0] DIG_ABC   = {32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128};

  initial begin
    vec_t         vecs[4];
    logic [511:0] m_empty, m_abc, m1, m2;
    logic [127:0] r, iv, r1;
    int           lat, accepted, dones, k, cyc;

    m_empty = '0;
    m_empty[31:0] = 32'h00000080;
    m_abc = '0;
    m_abc[31:0] = 32'h80636261;
    m_abc[14*32 +: 32] = 32'h00000018;
    vecs[0] = '{"empty_rpc1", 0, m_empty, IV, DIG_EMPTY};
    vecs[1] = '{"abc_rpc1",   0, m_abc,   IV, DIG_ABC};
    vecs[2] = '{"abc_rpc2",   1, m_abc,   IV, DIG_ABC};
    vecs[3] = '{"abc_rpc4",   2, m_abc,   IV, DIG_ABC};

    // Reset state
    rst_n = 1'b0;
    start_v = '0;
    message = '0;
    {a_in, b_in, c_in, d_in} = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ready%0d", i), 128'(ready_v[i]), 128'd1);
      check($sformatf("reset_busy%0d", i),  128'(busy_v[i]),  128'd0);
      check($sformatf("reset_done%0d", i),  128'(done_v[i]),  128'd0);
      check($sformatf("reset_out%0d", i),   res(i),           128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors, with latency, one-cycle done and output hold
    for (int v = 0; v < 4; v++) begin
      k = vecs[v].k;
      run_block(k, vecs[v].msg, vecs[v].iv, r, lat);
      check({vecs[v].name, "_result"}, r, from_digest(vecs[v].dig, vecs[v].iv));
      check({vecs[v].name, "_model"},  r, md5_ref(vecs[v].msg, vecs[v].iv));
      check({vecs[v].name, "_latency"}, 128'(lat), 128'(64 / rpc_of[k]));
      @(posedge clk);
      #1;
      check({vecs[v].name, "_done_pulse"}, 128'(done_v[k]), 128'd0);
      repeat (4) @(posedge clk);
      #1;
      check({vecs[v].name, "_hold"}, res(k), from_digest(vecs[v].dig, vecs[v].iv));
    end

    // Random blocks and chaining values against the model
    for (int n = 0; n < 9; n++) begin
      k = n % 3;
      m1 = rand_block();
      iv = {$urandom, $urandom, $urandom, $urandom};
      run_block(k, m1, iv, r, lat);
      check($sformatf("rand%0d_result", n), r, md5_ref(m1, iv));
      check($sformatf("rand%0d_latency", n), 128'(lat), 128'(64 / rpc_of[k]));
    end

    // start held high with changing inputs: only ready cycles accept
    accepted = 0;
    dones = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (done_v[0]) begin
        dones++;
        check("stream_no_gap", 128'(ready_v[0]), 128'd1);
        if (exp_q.size() > 0) check("stream_result", res(0), exp_q.pop_front());
        else check("stream_unexpected_done", 128'd1, 128'd0);
      end
      if (cyc == 300) start_v[0] = 1'b0;
      message = rand_block();
      {a_in, b_in, c_in, d_in} = {$urandom, $urandom, $urandom, $urandom};
      if (start_v[0] && ready_v[0]) begin
        exp_q.push_back(md5_ref(message, {a_in, b_in, c_in, d_in}));
        accepted++;
      end
      @(negedge clk);
    end
    check("stream_done_count", 128'(dones), 128'(accepted));
    check("stream_queue_empty", 128'(exp_q.size()), 128'd0);
    check("stream_accepts", 128'(accepted), 128'd5);

    // Reset during RUN at round 30
    @(negedge clk);
    message = m_abc;
    {a_in, b_in, c_in, d_in} = IV;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 128'(ready_v[0]), 128'd1);
    check("abort_busy",  128'(busy_v[0]),  128'd0);
    check("abort_done",  128'(done_v[0]),  128'd0);
    check("abort_out",   res(0),           128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check("abort_no_done", 128'(dones), 128'd0);
    run_block(0, m_abc, IV, r, lat);
    check("after_abort_result", r, from_digest(DIG_ABC, IV));
    check("after_abort_latency", 128'(lat), 128'd64);

    // start during RUN is ignored
    m1 = rand_block();
    m2 = rand_block();
    iv = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    message = m1;
    {a_in, b_in, c_in, d_in} = iv;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    dones = 0;
    r1 = '0;
    for (cyc = 0; cyc < 150; cyc++) begin
      if (cyc >= 5 && cyc < 40) begin
        start_v[0] = 1'b1;
        message = m2;
      end else begin
        start_v[0] = 1'b0;
      end
      @(negedge clk);
      if (done_v[0]) begin
        dones++;
        r1 = res(0);
      end
    end
    check("busy_start_done_count", 128'(dones), 128'd1);
    check("busy_start_result", r1, md5_ref(m1, iv));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
